lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator that sits between the execute stage and the data memory.
- Accepts one load or store at a time from the pipeline over a valid/ready handshake.
- Drives the memory's addr/width/we/data port and waits the memory's registered read latency.
- Returns load data or store completion on a response handshake.

Parameters:
- AW, 32, address width driven to memory.
- DW, 32, data width.
- LOAD_LAT, 1, cycles from the issue edge until memory read data is valid; range 1..15.

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_valid  input  1  pipeline presents a request.
- o_req_ready  output  1  block can accept a request; high only in IDLE.
- i_req_we  input  1  1 = store, 0 = load.
- i_req_funct3  input  3  RISC-V funct3. Bit0 = half, bit1 = word, bit2 = unsigned; 000 = byte.
- i_req_addr  input  AW  byte address.
- i_req_wdata  input  DW  store data.
- o_mem_addr  output  AW  memory address.
- o_mem_width  output  3  memory width code, equal to the captured funct3.
- o_mem_we  output  1  memory write enable.
- o_mem_data  output  DW  memory write data.
- i_mem_data  input  DW  memory read data (registered by the memory).
- i_mem_valid  input  1  memory valid; memory drives it as not-we.
- o_resp_valid  output  1  response available.
- i_resp_ready  input  1  pipeline takes the response.
- o_resp_rdata  output  DW  load result; 0 for stores.
- o_resp_err  output  1  misalignment error flag; see Optional Feature.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (async, i_rst=1):
  - state = IDLE, o_req_ready = 1, o_mem_we = 0.
  - o_mem_addr, o_mem_width, o_mem_data = 0.
  - o_resp_valid = 0, o_resp_rdata = 0, o_resp_err = 0.
  - The latency counter is cleared.
  - Reset mid-operation abandons the request. o_mem_we drops immediately (asynchronously), so no partial write is issued after reset assertion.
- IDLE:
  - On i_req_valid & o_req_ready: register we, funct3, addr and wdata onto the o_mem_* outputs; go to ISSUE.
  - o_mem_we stays 0 in IDLE.
- ISSUE (exactly 1 cycle): o_mem_we = captured we; address, width and data are held stable.
  - Store: next state RESP. Set o_resp_rdata = 0, o_resp_valid = 1, o_mem_we = 0.
  - Load: load the counter with LOAD_LAT-1 and go to WAIT. If LOAD_LAT = 1, go straight to the capture step.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0 and i_mem_valid = 1, capture i_mem_data into o_resp_rdata and go to RESP.
  - The memory does sign or zero extension; the block passes i_mem_data through unmodified.
  - If i_mem_valid = 0 at capture, stay in WAIT and retry each cycle.
- RESP:
  - o_resp_valid = 1 and o_resp_rdata is stable until i_resp_ready = 1.
  - On that handshake edge, clear o_resp_valid and go to IDLE; o_req_ready rises the next cycle.
- Latency, accept edge to o_resp_valid high:
  - store: 2 cycles.
  - load: 2 + LOAD_LAT cycles.
- Throughput: one request in flight. A new request is not accepted in the same cycle a response completes.
- i_req_valid while not ready is ignored; the request must be held by the pipeline.
- Memory outputs stay stable through WAIT/RESP. Only o_mem_we changes, and it is high only in ISSUE.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Enabled, at accept time:
  - Misaligned means half with addr[0] = 1, or word with addr[1:0] != 0.
  - A misaligned request skips ISSUE/WAIT and goes IDLE -> RESP next cycle.
  - In that response o_resp_err = 1 and o_resp_rdata = 0; o_mem_we never asserts.
  - o_resp_err clears with o_resp_valid.
- Disabled: no check; o_resp_err is tied 0.

Test Plan:
- Reset asserted mid-ISSUE of a store -> o_mem_we falls immediately, state IDLE, o_req_ready = 1. A subsequent load of that address returns the old value.
- SW addr=0x10 data=0xDEADBEEF, then LW addr=0x10 -> store resp after 2 cycles; load resp after 3 cycles with rdata=0xDEADBEEF; o_mem_we high exactly 1 cycle.
- Memory word=0x000080F0:
  - LB -> 0xFFFFFFF0.
  - LBU -> 0x000000F0.
  - LH -> 0xFFFF80F0.
  - LHU -> 0x000080F0.
- Backpressure: i_resp_ready held low for 5 cycles after a load -> o_resp_valid and o_resp_rdata stable all 5 cycles; a new i_req_valid is not accepted until after the handshake.
- LOAD_LAT=3, LW -> o_resp_valid rises 5 cycles after the accept edge.
- With LSU_MISALIGN_CHECK_EN, SW addr=0x12 -> o_resp_err=1 one cycle after accept, o_mem_we never high, memory unchanged. Without the macro, o_resp_err stays 0 for the same request.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - request, memory and response signals of the load/store master
interface lsu_mem_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [2:0]    i_req_funct3;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata;

  logic [AW-1:0] o_mem_addr;
  logic [2:0]    o_mem_width;
  logic          o_mem_we;
  logic [DW-1:0] o_mem_data;
  logic [DW-1:0] i_mem_data;
  logic          i_mem_valid;

  logic          o_resp_valid;
  logic          i_resp_ready;
  logic [DW-1:0] o_resp_rdata;
  logic          o_resp_err;

  modport master (
    input  i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_mem_data, i_mem_valid, i_resp_ready,
    output o_req_ready, o_mem_addr, o_mem_width, o_mem_we, o_mem_data,
    output o_resp_valid, o_resp_rdata, o_resp_err
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_funct3, i_req_addr, i_req_wdata,
    output i_mem_data, i_mem_valid, i_resp_ready,
    input  o_req_ready, o_mem_addr, o_mem_width, o_mem_we, o_mem_data,
    input  o_resp_valid, o_resp_rdata, o_resp_err
  );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - single-outstanding load/store initiator towards data memory
// Optional misalignment check: define LSU_MISALIGN_CHECK_EN.
module lsu_mem_master #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOAD_LAT = 1
) (
  input logic               i_clk,
  input logic               i_rst,
  lsu_mem_master_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [3:0]    lat_cnt;
  logic          req_ready_q;
  logic [AW-1:0] mem_addr_q;
  logic [2:0]    mem_width_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_data_q;
  logic          resp_valid_q;
  logic [DW-1:0] resp_rdata_q;

  assign bus.o_req_ready  = req_ready_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_width  = mem_width_q;
  assign bus.o_mem_we     = mem_we_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_resp_valid = resp_valid_q;
  assign bus.o_resp_rdata = resp_rdata_q;

`ifdef LSU_MISALIGN_CHECK_EN
  logic resp_err_q;
  logic req_misaligned;
  assign req_misaligned = (bus.i_req_funct3[0] & bus.i_req_addr[0]) |
                          (bus.i_req_funct3[1] & (bus.i_req_addr[1:0] != 2'b00));
  assign bus.o_resp_err = resp_err_q;
`else
  assign bus.o_resp_err = 1'b0;
`endif

  // Async reset also drops mem_we at once, so an abandoned store never lands.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      req_ready_q  <= 1'b1;
      mem_addr_q   <= '0;
      mem_width_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_data_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      resp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            mem_addr_q  <= bus.i_req_addr;
            mem_width_q <= bus.i_req_funct3;
            mem_data_q  <= bus.i_req_wdata;
`ifdef LSU_MISALIGN_CHECK_EN
            if (req_misaligned) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= 1'b1;
            end else begin
              state    <= ISSUE;
              mem_we_q <= bus.i_req_we;
            end
`else
            state    <= ISSUE;
            mem_we_q <= bus.i_req_we;
`endif
          end
        end
        ISSUE: begin
          mem_we_q <= 1'b0;
          if (mem_we_q) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            // With LOAD_LAT = 1 the counter starts at 0 and WAIT captures at once.
            lat_cnt <= 4'(LOAD_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else if (bus.i_mem_valid) begin
            resp_rdata_q <= bus.i_mem_data;
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.i_resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state        <= IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
            resp_err_q   <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master (LOAD_LAT 1 and 3)
module tb_lsu_mem_master;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef LSU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  lsu_mem_master_if #(.AW(AW), .DW(DW)) bus1 ();
  lsu_mem_master_if #(.AW(AW), .DW(DW)) bus3 ();

  lsu_mem_master #(.AW(AW), .DW(DW), .LOAD_LAT(1)) dut1 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus1.master));
  lsu_mem_master #(.AW(AW), .DW(DW), .LOAD_LAT(3)) dut3 (.i_clk(i_clk), .i_rst(i_rst), .bus(bus3.master));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-addressed memories: mem1/mem3 are the attached memories, ref_mem is the model's image.
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] ref_mem [256];

  function automatic logic [31:0] raw_at(input int sel, input logic [7:0] a);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      case (sel)
        0:       r[8*k +: 8] = ref_mem[a + 8'(k)];
        1:       r[8*k +: 8] = mem1[a + 8'(k)];
        default: r[8*k +: 8] = mem3[a + 8'(k)];
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] ld_ext(input logic [31:0] raw, input logic [2:0] f3);
    if (f3[1]) return raw;
    if (f3[0]) return f3[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
    return f3[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return f3[1] ? 4 : (f3[0] ? 2 : 1);
  endfunction

  function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
    return MIS_EN && ((f3[0] && a[0]) || (f3[1] && (a[1:0] != 2'b00)));
  endfunction

  // Memory with registered read: latency 1 for dut1, 3-deep pipe for dut3.
  logic [31:0] rd1, rd3_0, rd3_1, rd3_2;
  int we_cnt = 0;
  always @(posedge i_clk) begin
    if (bus1.o_mem_we) begin
      we_cnt <= we_cnt + 1;
      for (int k = 0; k < 4; k++)
        if (k < nbytes(bus1.o_mem_width)) mem1[bus1.o_mem_addr[7:0] + 8'(k)] <= bus1.o_mem_data[8*k +: 8];
    end
    if (bus3.o_mem_we) begin
      for (int k = 0; k < 4; k++)
        if (k < nbytes(bus3.o_mem_width)) mem3[bus3.o_mem_addr[7:0] + 8'(k)] <= bus3.o_mem_data[8*k +: 8];
    end
    rd1   <= ld_ext(raw_at(1, bus1.o_mem_addr[7:0]), bus1.o_mem_width);
    rd3_0 <= ld_ext(raw_at(2, bus3.o_mem_addr[7:0]), bus3.o_mem_width);
    rd3_1 <= rd3_0;
    rd3_2 <= rd3_1;
  end
  assign bus1.i_mem_data  = rd1;
  assign bus1.i_mem_valid = ~bus1.o_mem_we;
  assign bus3.i_mem_data  = rd3_2;
  assign bus3.i_mem_valid = ~bus3.o_mem_we;

  // Transaction-level model of dut1: one request in flight, response due a fixed latency after accept.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  int          m_acc, m_due;
  bit          m_we, m_mis;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_busy <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (!m_busy && bus1.i_req_valid) begin
        m_busy  <= 1'b1;
        m_acc   <= cyc;
        m_we    <= bus1.i_req_we;
        m_mis   <= is_mis(bus1.i_req_funct3, bus1.i_req_addr);
        m_f3    <= bus1.i_req_funct3;
        m_addr  <= bus1.i_req_addr;
        m_wdata <= bus1.i_req_wdata;
        m_due   <= cyc + (is_mis(bus1.i_req_funct3, bus1.i_req_addr) ? 1 : (bus1.i_req_we ? 2 : 3));
        m_rdata <= (bus1.i_req_we || is_mis(bus1.i_req_funct3, bus1.i_req_addr)) ? 32'h0 :
                   ld_ext(raw_at(0, bus1.i_req_addr[7:0]), bus1.i_req_funct3);
      end else if (m_busy && cyc >= m_due && bus1.i_resp_ready) begin
        m_busy <= 1'b0;
        if (m_we && !m_mis)
          for (int k = 0; k < 4; k++)
            if (k < nbytes(m_f3)) ref_mem[m_addr[7:0] + 8'(k)] <= m_wdata[8*k +: 8];
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      check("req_ready", 32'(bus1.o_req_ready), 32'(!m_busy));
      check("resp_valid", 32'(bus1.o_resp_valid), 32'(m_busy && cyc >= m_due));
      check("mem_we", 32'(bus1.o_mem_we), 32'(m_busy && m_we && !m_mis && cyc == m_acc + 1));
      if (m_busy && cyc >= m_due) begin
        check("resp_rdata", bus1.o_resp_rdata, m_rdata);
        check("resp_err", 32'(bus1.o_resp_err), 32'(m_mis));
      end else begin
        check("resp_err_idle", 32'(bus1.o_resp_err), 32'h0);
      end
      if (m_busy && !m_mis) begin
        check("mem_addr", bus1.o_mem_addr, m_addr);
        check("mem_width", 32'(bus1.o_mem_width), 32'(m_f3));
        check("mem_data", bus1.o_mem_data, m_wdata);
      end
    end
  end

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge i_clk);
    bus1.i_req_valid  = 1'b1;
    bus1.i_req_we     = we;
    bus1.i_req_funct3 = f3;
    bus1.i_req_addr   = addr;
    bus1.i_req_wdata  = wdata;
  endtask

  task automatic wait_accept();
    for (int i = 0; i < 30; i++) begin
      if (bus1.o_req_ready) begin
        @(posedge i_clk);
        #1 bus1.i_req_valid = 1'b0;
        return;
      end
      @(negedge i_clk);
    end
    tests++; fails++;
    $display("FAIL accept_timeout: got no req_ready, expected req_ready within 30 cycles");
    bus1.i_req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus1.o_resp_valid) return;
      lat++;
    end
    tests++; fails++;
    $display("FAIL resp_timeout: got no resp_valid, expected resp_valid within 40 cycles");
  endtask

  task automatic take_resp(input int hold, output logic [31:0] rd, output logic err);
    rd  = bus1.o_resp_rdata;
    err = bus1.o_resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge i_clk);
      check("hold_rdata", bus1.o_resp_rdata, rd);
      check("hold_valid", 32'(bus1.o_resp_valid), 32'h1);
      check("hold_ready", 32'(bus1.o_req_ready), 32'h0);
    end
    @(negedge i_clk);
    bus1.i_resp_ready = 1'b1;
    @(posedge i_clk);
    #1 bus1.i_resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic err, output int lat);
    drive_req(we, f3, addr, wdata);
    wait_accept();
    wait_resp(lat);
    take_resp(0, rd, err);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat, we0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] <= 8'(i); mem3[i] <= 8'(i); ref_mem[i] <= 8'(i);
    end
    for (int k = 0; k < 4; k++) begin
      mem1[8'h20 + k] <= 8'(32'h11223344 >> (8*k)); ref_mem[8'h20 + k] <= 8'(32'h11223344 >> (8*k));
      mem1[8'h30 + k] <= 8'(32'h000080F0 >> (8*k)); ref_mem[8'h30 + k] <= 8'(32'h000080F0 >> (8*k));
      mem3[8'h30 + k] <= 8'(32'h000080F0 >> (8*k));
    end
    bus1.i_req_valid = 1'b0; bus1.i_req_we = 1'b0; bus1.i_req_funct3 = 3'b0;
    bus1.i_req_addr = '0; bus1.i_req_wdata = '0; bus1.i_resp_ready = 1'b0;
    bus3.i_req_valid = 1'b0; bus3.i_req_we = 1'b0; bus3.i_req_funct3 = 3'b0;
    bus3.i_req_addr = '0; bus3.i_req_wdata = '0; bus3.i_resp_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    check("rst_ready", 32'(bus1.o_req_ready), 32'h1);
    check("rst_we", 32'(bus1.o_mem_we), 32'h0);
    check("rst_resp_valid", 32'(bus1.o_resp_valid), 32'h0);
    check("rst_rdata", bus1.o_resp_rdata, 32'h0);
    check("rst_mem_addr", bus1.o_mem_addr, 32'h0);

    we0 = we_cnt;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, err, lat);
    check("sw_latency", 32'(lat), 32'd2);
    check("sw_rdata", rd, 32'h0);
    check("sw_we_cycles", 32'(we_cnt - we0), 32'd1);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat);
    check("lw_latency", 32'(lat), 32'd3);
    check("lw_rdata", rd, 32'hDEADBEEF);

    do_req(1'b0, 3'b000, 32'h30, 32'h0, rd, err, lat); check("lb", rd, 32'hFFFFFFF0);
    do_req(1'b0, 3'b100, 32'h30, 32'h0, rd, err, lat); check("lbu", rd, 32'h000000F0);
    do_req(1'b0, 3'b001, 32'h30, 32'h0, rd, err, lat); check("lh", rd, 32'hFFFF80F0);
    do_req(1'b0, 3'b101, 32'h30, 32'h0, rd, err, lat); check("lhu", rd, 32'h000080F0);

    // Backpressure with a second request already waiting.
    drive_req(1'b0, 3'b010, 32'h20, 32'h0);
    wait_accept();
    wait_resp(lat);
    drive_req(1'b0, 3'b101, 32'h10, 32'h0);
    take_resp(5, rd, err);
    check("bp_rdata", rd, 32'h11223344);
    wait_accept();
    wait_resp(lat);
    take_resp(0, rd, err);
    check("bp_next_latency", 32'(lat), 32'd3);
    check("bp_next_rdata", rd, 32'h0000BEEF);

    // Reset asserted while the store sits in ISSUE.
    drive_req(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5);
    wait_accept();
    check("issue_we_high", 32'(bus1.o_mem_we), 32'h1);
    #2 i_rst = 1'b1;
    #1;
    check("rst_async_we", 32'(bus1.o_mem_we), 32'h0);
    check("rst_async_ready", 32'(bus1.o_req_ready), 32'h1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, err, lat);
    check("after_rst_lw", rd, 32'h11223344);

    we0 = we_cnt;
    do_req(1'b1, 3'b010, 32'h12, 32'hCAFEF00D, rd, err, lat);
    check("mis_latency", 32'(lat), MIS_EN ? 32'd1 : 32'd2);
    check("mis_err", 32'(err), MIS_EN ? 32'h1 : 32'h0);
    check("mis_we_cycles", 32'(we_cnt - we0), MIS_EN ? 32'd0 : 32'd1);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat);
    check("mis_mem_word", rd, MIS_EN ? 32'hDEADBEEF : 32'hF00DBEEF);

    // LOAD_LAT = 3 instance.
    @(negedge i_clk);
    bus3.i_req_valid = 1'b1; bus3.i_req_we = 1'b0; bus3.i_req_funct3 = 3'b010; bus3.i_req_addr = 32'h30;
    check("lat3_ready", 32'(bus3.o_req_ready), 32'h1);
    @(posedge i_clk);
    #1 bus3.i_req_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge i_clk);
      if (bus3.o_resp_valid) break;
      lat++;
    end
    check("lat3_latency", 32'(lat), 32'd5);
    check("lat3_rdata", bus3.o_resp_rdata, 32'h000080F0);
    bus3.i_resp_ready = 1'b1;
    @(posedge i_clk);
    #1 bus3.i_resp_ready = 1'b0;
    @(negedge i_clk);
    check("lat3_done", 32'(bus3.o_resp_valid), 32'h0);

    repeat (2) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
